// File: rtl/pc_redirect_ctrl.sv
// PC redirect arbiter: picks one of trap/mret/branch targets, offers it to IF over
// valid/ready, and holds the IF/ID/EX flushes through the handshake and drain window.
module pc_redirect_ctrl #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bj_ena,
    input  logic [ADDR_W-1:0] bj_pc,
    input  logic              trap_ena,
    input  logic [ADDR_W-1:0] trap_pc,
    input  logic              ret_ena,
    input  logic [ADDR_W-1:0] ret_pc,
    input  logic              if_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              bj_misalign,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam int unsigned DRAIN_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;
    typedef enum logic [1:0] {SrcNone, SrcBj, SrcRet, SrcTrap} src_e;

    state_e             state_q, state_d;
    src_e               src_q, src_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               misalign_q, misalign_d;
    logic               bj_req;

    // A target with bit1 set is not a legal fetch target; the trap unit takes over.
    assign bj_req = bj_ena & ~bj_pc[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            src_q      <= SrcNone;
            pc_q       <= '0;
            drain_q    <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            pc_q       <= pc_d;
            drain_q    <= drain_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        pc_d       = pc_q;
        drain_d    = drain_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trap_ena) begin
                    state_d = StIssue;
                    src_d   = SrcTrap;
                    pc_d    = trap_pc;
                end else if (ret_ena) begin
                    state_d = StIssue;
                    src_d   = SrcRet;
                    pc_d    = ret_pc;
                end else if (bj_req) begin
                    state_d = StIssue;
                    src_d   = SrcBj;
                    pc_d    = {bj_pc[ADDR_W-1:1], 1'b0};
                end else if (bj_ena) begin
                    misalign_d = 1'b1;
                end
            end
            StIssue: begin
                if (if_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (trap_ena) begin
                        // Old target consumed; the trap is a fresh redirect with no drain.
                        src_d = SrcTrap;
                        pc_d  = trap_pc;
                    end else if (FLUSH_CYCLES == 1) begin
                        state_d = StIdle;
                        src_d   = SrcNone;
                    end else begin
                        state_d = StDrain;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (trap_ena && src_q != SrcTrap) begin
                    src_d = SrcTrap;
                    pc_d  = trap_pc;
                end
            end
            StDrain: begin
                if (trap_ena) begin
                    state_d = StIssue;
                    src_d   = SrcTrap;
                    pc_d    = trap_pc;
                    drain_d = '0;
                end else if (drain_q == '0) begin
                    state_d = StIdle;
                    src_d   = SrcNone;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        redirect_valid = (state_q == StIssue);
        flush_if       = (state_q != StIdle);
        flush_id       = (state_q != StIdle);
        flush_ex       = (state_q != StIdle);
        redirect_pc    = pc_q;
        bj_misalign    = misalign_q;
        redirect_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: table of single-request vectors plus hand-written
// preemption/drain/reset sequences; consumed targets are checked via a queue.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bj_ena, trap_ena, ret_ena, if_ready;
    logic [63:0] bj_pc, trap_pc, ret_pc;
    logic        redirect_valid, flush_if, flush_id, flush_ex, bj_misalign;
    logic [63:0] redirect_pc;
    logic [31:0] redirect_cnt;
    // Narrow-counter copy to reach the wrap point quickly.
    logic        s_valid, s_fif, s_fid, s_fex, s_mis;
    logic [63:0] s_pc;
    logic [1:0]  s_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int exp_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.ADDR_W(64), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bj_ena(bj_ena), .bj_pc(bj_pc), .trap_ena(trap_ena),
        .trap_pc(trap_pc), .ret_ena(ret_ena), .ret_pc(ret_pc), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_if(flush_if),
        .flush_id(flush_id), .flush_ex(flush_ex), .bj_misalign(bj_misalign),
        .redirect_cnt(redirect_cnt)
    );

    pc_redirect_ctrl #(.ADDR_W(64), .FLUSH_CYCLES(2), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .bj_ena(bj_ena), .bj_pc(bj_pc), .trap_ena(trap_ena),
        .trap_pc(trap_pc), .ret_ena(ret_ena), .ret_pc(ret_pc), .if_ready(if_ready),
        .redirect_valid(s_valid), .redirect_pc(s_pc), .flush_if(s_fif),
        .flush_id(s_fid), .flush_ex(s_fex), .bj_misalign(s_mis), .redirect_cnt(s_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bj_ena = 1'b0;
        trap_ena = 1'b0;
        ret_ena = 1'b0;
    endtask

    task automatic chk_cnt(input string name);
        chk(name, redirect_cnt, 64'(exp_cnt));
        chk({name, "_w"}, s_cnt, 64'(exp_cnt % 4));
    endtask

    // Scoreboard: every handshake must consume the oldest expected target.
    always @(negedge clk) begin
        if (!rst && redirect_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got handshake pc %h want none", redirect_pc);
            end else begin
                chk("sb_pc", redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        trap, ret, bj;
        logic [63:0] tpc, rpc, bpc;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic        exp_mis;
    } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h80000011, 1'b1, 64'h80000010, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 64'h80000100, 64'h80000200, 64'h80000300,
                    1'b1, 64'h80000100, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h80000006, 1'b0, 64'h0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h80000200, 64'h80000300,
                    1'b1, 64'h80000200, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h123456789abcdef1, 64'h0,
                    1'b1, 64'h123456789abcdef1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 64'h80000100, 64'h0, 64'h80000006,
                    1'b1, 64'h80000100, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 64'hfffffffffffffff9,
                    1'b1, 64'hfffffffffffffff8, 1'b0};

        clr();
        bj_pc = '0; trap_pc = '0; ret_pc = '0;
        if_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", redirect_valid, 0);
        chk("rst_flush", {flush_if, flush_id, flush_ex}, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_mis", bj_misalign, 0);
        chk_cnt("rst_cnt");
        tick();
        tick();
        rst = 1'b0;
        if_ready = 1'b1;
        tick();

        foreach (vecs[i]) begin
            trap_ena = vecs[i].trap; ret_ena = vecs[i].ret; bj_ena = vecs[i].bj;
            trap_pc = vecs[i].tpc; ret_pc = vecs[i].rpc; bj_pc = vecs[i].bpc;
            if (vecs[i].exp_valid) begin
                exp_q.push_back(vecs[i].exp_pc);
                exp_cnt++;
            end
            tick();
            clr();
            chk($sformatf("v%0d_valid", i), redirect_valid, vecs[i].exp_valid);
            chk($sformatf("v%0d_flush", i), flush_if, vecs[i].exp_valid);
            chk($sformatf("v%0d_mis", i), bj_misalign, vecs[i].exp_mis);
            if (vecs[i].exp_valid) chk($sformatf("v%0d_pc", i), redirect_pc, vecs[i].exp_pc);
            tick();
            chk($sformatf("v%0d_mis_end", i), bj_misalign, 0);
            chk($sformatf("v%0d_drain1", i), {flush_if, flush_id, flush_ex, redirect_valid},
                vecs[i].exp_valid ? 4'b1110 : 4'b0000);
            tick();
            chk($sformatf("v%0d_drain2", i), flush_ex, vecs[i].exp_valid);
            tick();
            chk($sformatf("v%0d_idle", i), {flush_if, flush_id, flush_ex, redirect_valid}, 0);
            chk_cnt($sformatf("v%0d_cnt", i));
        end

        // ret held off by IF, trap preempts it; a second trap does not.
        if_ready = 1'b0;
        ret_ena = 1'b1; ret_pc = 64'h80000200;
        tick();
        clr();
        chk("pre_ret_pc", redirect_pc, 64'h80000200);
        tick();
        trap_ena = 1'b1; trap_pc = 64'h80000100;
        bj_ena = 1'b1; bj_pc = 64'h80000300;
        exp_q.push_back(64'h80000100);
        tick();
        clr();
        chk("pre_trap_pc", redirect_pc, 64'h80000100);
        chk("pre_valid", redirect_valid, 1);
        trap_ena = 1'b1; trap_pc = 64'h80000900;
        tick();
        clr();
        chk("pre_first_trap_wins", redirect_pc, 64'h80000100);
        if_ready = 1'b1;
        exp_cnt++;
        tick();
        if_ready = 1'b0;
        chk("pre_drain", {redirect_valid, flush_if}, 2'b01);
        chk_cnt("pre_cnt");
        tick();
        tick();
        chk("pre_idle", flush_id, 0);

        // Handshake coinciding with a trap, then a trap during drain.
        if_ready = 1'b1;
        bj_ena = 1'b1; bj_pc = 64'h80000400;
        exp_q.push_back(64'h80000400);
        tick();
        clr();
        trap_ena = 1'b1; trap_pc = 64'h80000500;
        exp_q.push_back(64'h80000500);
        exp_cnt++;
        tick();
        clr();
        chk("hs_trap_valid", redirect_valid, 1);
        chk("hs_trap_pc", redirect_pc, 64'h80000500);
        chk_cnt("hs_trap_cnt");
        exp_cnt++;
        tick();
        chk("hs_drain", {redirect_valid, flush_if}, 2'b01);
        trap_ena = 1'b1; trap_pc = 64'h80000600;
        exp_q.push_back(64'h80000600);
        tick();
        clr();
        chk("drain_trap_valid", redirect_valid, 1);
        chk("drain_trap_pc", redirect_pc, 64'h80000600);
        exp_cnt++;
        tick();
        bj_ena = 1'b1; bj_pc = 64'h80000700;
        ret_ena = 1'b1; ret_pc = 64'h80000800;
        tick();
        clr();
        chk("drain_ignore_bj", {redirect_valid, flush_if}, 2'b01);
        tick();
        chk("drain_done", {redirect_valid, flush_if}, 0);
        chk_cnt("drain_cnt");

        // Asynchronous reset in the middle of an ISSUE.
        if_ready = 1'b0;
        bj_ena = 1'b1; bj_pc = 64'h80000800;
        tick();
        clr();
        chk("mid_valid", redirect_valid, 1);
        #2;
        rst = 1'b1;
        exp_cnt = 0;
        #1;
        chk("arst_valid", redirect_valid, 0);
        chk("arst_flush", {flush_if, flush_id, flush_ex}, 0);
        chk("arst_pc", redirect_pc, 0);
        chk_cnt("arst_cnt");
        tick();
        rst = 1'b0;
        if_ready = 1'b1;
        bj_ena = 1'b1; bj_pc = 64'h80000a01;
        exp_q.push_back(64'h80000a00);
        exp_cnt++;
        tick();
        clr();
        chk("post_valid", redirect_valid, 1);
        chk("post_pc", redirect_pc, 64'h80000a00);
        tick();
        tick();
        tick();
        chk("post_idle", flush_if, 0);
        chk_cnt("post_cnt");
        chk("sb_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
